// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline control block.
package pipe_pkg;

   localparam int RF_ADDR_W = 5;
   localparam logic [RF_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [RF_ADDR_W-1:0] rs1;
      logic [RF_ADDR_W-1:0] rs2;
      logic [RF_ADDR_W-1:0] rd;
      logic                 regwrite;
      logic                 memread;
      logic                 memwrite;
   } stage_meta_t;

   typedef enum logic {
      RUN     = 1'b0,
      MEMWAIT = 1'b1
   } ctrl_state_e;

   // A stage that does not really write the RF carries rd=0/regwrite=0, so the
   // forwarding unit never sees a live-looking destination without a write.
   function automatic stage_meta_t meta_canon(input stage_meta_t m);
      stage_meta_t r;
      r = m;
      if (!m.regwrite || (m.rd == REG_ZERO)) begin
         r.rd       = REG_ZERO;
         r.regwrite = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/pipe_meta_reg.sv
// One pipeline-stage hazard metadata register (flush wins over enable).
module pipe_meta_reg
   import pipe_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        flush,
   input  stage_meta_t d,
   output stage_meta_t q
);

   // Capture canonicalised metadata when enabled, load a bubble on flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (flush) begin
         q <= '0;
      end else if (en) begin
         q <= meta_canon(d);
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control and hazard block: load-use stall, branch flush and
// data-memory wait handling, plus stage metadata for the forwarding unit.
// Optional macro PIPE_PERF_CNT_EN adds perf_lu_stalls / perf_flushes /
// perf_mem_wait event counters (CNT_W bits, wrapping).
//
// state   | meaning
// --------+------------------------------------------------------------
// RUN     | normal flow; hazards checked in order mem wait, branch, load-use
// MEMWAIT | EX/MEM load/store waiting on dmem_ready; front of pipe held,
//         | MEM/WB fed bubbles, wait counter running (saturating)
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int XLEN_RF_ADDR = 5,
   parameter int MEM_TIMEOUT  = 16
`ifdef PIPE_PERF_CNT_EN
   ,parameter int CNT_W       = 32
`endif
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    id_valid,
   input  logic [XLEN_RF_ADDR-1:0] id_rs1,
   input  logic [XLEN_RF_ADDR-1:0] id_rs2,
   input  logic [XLEN_RF_ADDR-1:0] id_rd,
   input  logic                    id_regwrite,
   input  logic                    id_memread,
   input  logic                    id_memwrite,
   input  logic                    ex_branch_taken,
   input  logic                    dmem_ready,
   output logic                    pc_en,
   output logic                    ifid_en,
   output logic                    ifid_flush,
   output logic                    idex_flush,
   output logic                    pipe_hold,
   output logic [XLEN_RF_ADDR-1:0] ex_src1,
   output logic [XLEN_RF_ADDR-1:0] ex_src2,
   output logic [XLEN_RF_ADDR-1:0] exmem_dest,
   output logic [XLEN_RF_ADDR-1:0] memwb_dest,
   output logic                    exmem_regwrite,
   output logic                    memwb_regwrite,
   output logic                    mem_err
`ifdef PIPE_PERF_CNT_EN
   ,output logic [CNT_W-1:0]       perf_lu_stalls
   ,output logic [CNT_W-1:0]       perf_flushes
   ,output logic [CNT_W-1:0]       perf_mem_wait
`endif
);

   localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

   stage_meta_t       id_meta;
   stage_meta_t       idex_q;
   stage_meta_t       exmem_q;
   stage_meta_t       memwb_q;
   ctrl_state_e       state_q;
   ctrl_state_e       state_d;
   logic [WCNT_W-1:0] wait_cnt_q;
   logic [WCNT_W-1:0] wait_cnt_d;
   logic              mem_op;
   logic              hold;
   logic              load_use;
   logic              err_set;
   logic              meta_unused;

   // An invalid ID slot enters ID/EX as a bubble.
   always_comb begin
      id_meta = '0;
      if (id_valid) begin
         id_meta.rs1      = id_rs1;
         id_meta.rs2      = id_rs2;
         id_meta.rd       = id_rd;
         id_meta.regwrite = id_regwrite;
         id_meta.memread  = id_memread;
         id_meta.memwrite = id_memwrite;
      end
   end

   assign mem_op   = exmem_q.memread | exmem_q.memwrite;
   assign load_use = id_valid & idex_q.memread & (idex_q.rd != REG_ZERO) &
                     ((idex_q.rd == id_rs1) | (idex_q.rd == id_rs2));

   // Next state, wait counter and stage controls; outputs forced idle in reset.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      err_set    = 1'b0;
      hold       = 1'b0;
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      pipe_hold  = 1'b0;

      case (state_q)
         RUN: begin
            hold = mem_op & ~dmem_ready;
            if (hold) state_d = MEMWAIT;
         end
         MEMWAIT: begin
            hold = ~dmem_ready;
            if (!hold) state_d = RUN;
         end
         default: state_d = RUN;
      endcase

      // The cycle that enters MEMWAIT is the first counted wait cycle.
      if (state_d == MEMWAIT) begin
         wait_cnt_d = (wait_cnt_q == WCNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
         err_set    = (wait_cnt_d == WCNT_MAX);
      end

      if (rst) begin
         pc_en   = 1'b0;
         ifid_en = 1'b0;
      end else if (hold) begin
         pc_en     = 1'b0;
         ifid_en   = 1'b0;
         pipe_hold = 1'b1;
      end else if (ex_branch_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (load_use) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end
   end

   // FSM state, wait counter and the sticky timeout flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         mem_err    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if (err_set) mem_err <= 1'b1;
      end
   end

   pipe_meta_reg u_idex (
      .clk   (clk),
      .rst   (rst),
      .en    (~pipe_hold),
      .flush (idex_flush),
      .d     (id_meta),
      .q     (idex_q)
   );

   pipe_meta_reg u_exmem (
      .clk   (clk),
      .rst   (rst),
      .en    (~pipe_hold),
      .flush (1'b0),
      .d     (idex_q),
      .q     (exmem_q)
   );

   pipe_meta_reg u_memwb (
      .clk   (clk),
      .rst   (rst),
      .en    (1'b1),
      .flush (pipe_hold),
      .d     (exmem_q),
      .q     (memwb_q)
   );

   assign ex_src1        = idex_q.rs1;
   assign ex_src2        = idex_q.rs2;
   assign exmem_dest     = exmem_q.rd;
   assign exmem_regwrite = exmem_q.regwrite;
   assign memwb_dest     = memwb_q.rd;
   assign memwb_regwrite = memwb_q.regwrite;

   // Later-stage source fields are carried along but not needed here.
   assign meta_unused = ^{idex_q.regwrite, idex_q.memwrite,
                          exmem_q.rs1, exmem_q.rs2,
                          memwb_q.rs1, memwb_q.rs2, memwb_q.memread, memwb_q.memwrite};

`ifdef PIPE_PERF_CNT_EN
   // Event counters: one count per cycle of each condition, free-running wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_lu_stalls <= '0;
         perf_flushes   <= '0;
         perf_mem_wait  <= '0;
      end else begin
         if (idex_flush && !ifid_flush) perf_lu_stalls <= perf_lu_stalls + 1'b1;
         if (ifid_flush)                perf_flushes   <= perf_flushes + 1'b1;
         if (pipe_hold)                 perf_mem_wait  <= perf_mem_wait + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver applies one input vector per clock,
// predicts the cycle's outputs from an instruction-level pipeline model and
// queues them; a monitor pops and compares on the falling edge.
module tb_pipe_ctrl;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_valid = 1'b0;
   logic [4:0] id_rs1 = '0;
   logic [4:0] id_rs2 = '0;
   logic [4:0] id_rd = '0;
   logic       id_regwrite = 1'b0;
   logic       id_memread = 1'b0;
   logic       id_memwrite = 1'b0;
   logic       ex_branch_taken = 1'b0;
   logic       dmem_ready = 1'b1;
   logic       pc_en, ifid_en, ifid_flush, idex_flush, pipe_hold;
   logic [4:0] ex_src1, ex_src2, exmem_dest, memwb_dest;
   logic       exmem_regwrite, memwb_regwrite, mem_err;

   pipe_ctrl #(.XLEN_RF_ADDR(5), .MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
      .id_memwrite(id_memwrite), .ex_branch_taken(ex_branch_taken),
      .dmem_ready(dmem_ready), .pc_en(pc_en), .ifid_en(ifid_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .pipe_hold(pipe_hold),
      .ex_src1(ex_src1), .ex_src2(ex_src2), .exmem_dest(exmem_dest),
      .memwb_dest(memwb_dest), .exmem_regwrite(exmem_regwrite),
      .memwb_regwrite(memwb_regwrite), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      bit         rw, mr, mw;
   } ins_t;

   typedef struct packed {
      logic pc_en, ifid_en, ifid_flush, idex_flush, pipe_hold, mem_err;
   } ctrl_t;

   typedef struct packed {
      logic [4:0] src1, src2, exd, wbd;
      logic       exrw, wbrw;
   } fwd_t;

   typedef struct packed {
      ctrl_t c;
      fwd_t  f;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   // Model: the three instructions sitting in EX, MEM, WB.
   ins_t m_ex, m_mem, m_wb;
   int   m_wait;
   bit   m_err;

   function automatic ins_t bubble();
      ins_t b;
      b.rs1 = '0; b.rs2 = '0; b.rd = '0; b.rw = 0; b.mr = 0; b.mw = 0;
      return b;
   endfunction

   function automatic ins_t canon(ins_t i);
      ins_t r = i;
      if (!i.rw || i.rd == 5'd0) begin
         r.rd = '0;
         r.rw = 0;
      end
      return r;
   endfunction

   task automatic model_step();
      exp_t e;
      ins_t idi;
      bit   waiting, lu, fl, st;
      e = '0;
      if (rst) begin
         sbq.push_back(e);
         m_ex = bubble(); m_mem = bubble(); m_wb = bubble();
         m_wait = 0; m_err = 0;
         return;
      end
      waiting = (m_mem.mr || m_mem.mw) && !dmem_ready;
      lu = id_valid && m_ex.mr && m_ex.rd != 0 &&
           (m_ex.rd == id_rs1 || m_ex.rd == id_rs2);
      fl = !waiting && ex_branch_taken;
      st = !waiting && !ex_branch_taken && lu;

      e.c.pc_en      = !(waiting || st);
      e.c.ifid_en    = !(waiting || st);
      e.c.ifid_flush = fl;
      e.c.idex_flush = fl || st;
      e.c.pipe_hold  = waiting;
      e.c.mem_err    = m_err;
      e.f.src1 = m_ex.rs1;
      e.f.src2 = m_ex.rs2;
      e.f.exd  = m_mem.rd;
      e.f.exrw = m_mem.rw;
      e.f.wbd  = m_wb.rd;
      e.f.wbrw = m_wb.rw;
      sbq.push_back(e);

      if (waiting) begin
         m_wb   = bubble();
         m_wait = (m_wait < TO) ? m_wait + 1 : TO;
         if (m_wait == TO) m_err = 1;
      end else begin
         idi.rs1 = id_rs1; idi.rs2 = id_rs2; idi.rd = id_rd;
         idi.rw = id_regwrite; idi.mr = id_memread; idi.mw = id_memwrite;
         m_wb   = m_mem;
         m_mem  = m_ex;
         m_ex   = (fl || st || !id_valid) ? bubble() : canon(idi);
         m_wait = 0;
      end
   endtask

   task automatic drive(input bit r, input bit v, input int s1, input int s2,
                        input int d, input bit rw, input bit mr, input bit mw,
                        input bit br, input bit rdy);
      @(posedge clk);
      #1;
      rst             = r;
      id_valid        = v;
      id_rs1          = 5'(s1);
      id_rs2          = 5'(s2);
      id_rd           = 5'(d);
      id_regwrite     = rw;
      id_memread      = mr;
      id_memwrite     = mw;
      ex_branch_taken = br;
      dmem_ready      = rdy;
      cyc++;
      model_step();
   endtask

   task automatic nop(input bit rdy, input int n);
      for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
   endtask

   // Monitor: compare each queued cycle expectation at the falling edge.
   initial begin
      exp_t  e;
      ctrl_t ac;
      fwd_t  af;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e  = sbq.pop_front();
            ac = {pc_en, ifid_en, ifid_flush, idex_flush, pipe_hold, mem_err};
            af = {ex_src1, ex_src2, exmem_dest, memwb_dest, exmem_regwrite, memwb_regwrite};
            n_cmp++;
            if (ac !== e.c) begin
               n_bad++;
               $display("FAIL ctrl cyc=%0d got pc_en/ifid_en/ifid_fl/idex_fl/hold/err=%b required=%b",
                        cyc, ac, e.c);
            end
            n_cmp++;
            if (af !== e.f) begin
               n_bad++;
               $display("FAIL fwd cyc=%0d got src1=%0d src2=%0d exd=%0d wbd=%0d exrw=%b wbrw=%b required src1=%0d src2=%0d exd=%0d wbd=%0d exrw=%b wbrw=%b",
                        cyc, af.src1, af.src2, af.exd, af.wbd, af.exrw, af.wbrw,
                        e.f.src1, e.f.src2, e.f.exd, e.f.wbd, e.f.exrw, e.f.wbrw);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      // reset
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      nop(1, 2);

      // load x5 then add x6,x5,x1 (stalls one cycle, ID re-presents it)
      drive(0, 1, 1, 2, 5, 1, 1, 0, 0, 1);
      drive(0, 1, 5, 1, 6, 1, 0, 0, 0, 1);
      drive(0, 1, 5, 1, 6, 1, 0, 0, 0, 1);
      nop(1, 3);

      // addi x0,x0,1 never shows a destination
      drive(0, 1, 0, 0, 0, 1, 0, 0, 0, 1);
      nop(1, 3);

      // branch taken while load-use is true
      drive(0, 1, 3, 4, 7, 1, 1, 0, 0, 1);
      drive(0, 1, 7, 0, 8, 1, 0, 0, 1, 1);
      nop(1, 3);

      // load x9, dmem not ready for 3 cycles
      drive(0, 1, 2, 3, 9, 1, 1, 0, 0, 1);
      nop(1, 1);
      nop(0, 3);
      nop(1, 3);

      // timeout: load x10, dmem stuck low, then reset inside the wait
      drive(0, 1, 2, 3, 10, 1, 1, 0, 0, 0);
      nop(0, 22);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nop(1, 3);

      // store in EX/MEM also waits
      drive(0, 1, 1, 2, 0, 0, 0, 1, 0, 1);
      nop(1, 1);
      nop(0, 2);
      nop(1, 2);

      // randomized traffic with frequent hazards
      for (int i = 0; i < 3000; i++) begin
         drive(0,
               $urandom_range(0, 99) < 85,
               int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)),
               $urandom_range(0, 99) < 75,
               $urandom_range(0, 99) < 30,
               $urandom_range(0, 99) < 15,
               $urandom_range(0, 99) < 10,
               $urandom_range(0, 99) < 75);
      end

      @(negedge clk);
      #1;
      n_cmp++;
      if (sbq.size() != 0) begin
         n_bad++;
         $display("FAIL drain left=%0d required=0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control and hazard block for the 5-stage core. Sits directly upstream of the forwarding unit.
- Registers the per-stage hazard metadata (rs1/rs2/rd/regwrite/memread) for ID/EX, EX/MEM and MEM/WB, and presents EX-stage sources plus EX/MEM and MEM/WB destinations to the forwarding unit.
- Detects load-use hazards, branch flushes and multi-cycle data-memory waits, and drives stage enables and flushes through a small FSM.

Parameters:
- XLEN_RF_ADDR, 5, register-file index width
- MEM_TIMEOUT, 16, max dmem wait cycles before mem_err is raised
- CNT_W, 32, width of performance counters (optional feature only)

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous reset, active high
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  5  ID source 1 index
- id_rs2  in  5  ID source 2 index
- id_rd  in  5  ID destination index
- id_regwrite  in  1  ID instruction writes the RF
- id_memread  in  1  ID instruction is a load
- id_memwrite  in  1  ID instruction is a store
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- dmem_ready  in  1  data memory completes the current access this cycle
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID becomes a bubble
- idex_flush  out  1  ID/EX becomes a bubble
- pipe_hold  out  1  EX/MEM and ID/EX hold (memory wait)
- ex_src1  out  5  ID/EX rs1, to forwarding unit src1
- ex_src2  out  5  ID/EX rs2, to forwarding unit src2
- exmem_dest  out  5  EX/MEM rd, to forwarding unit EXMEM_dest
- memwb_dest  out  5  MEM/WB rd, to forwarding unit MEMWB_dest
- exmem_regwrite  out  1  EX/MEM writes the RF
- memwb_regwrite  out  1  MEM/WB writes the RF
- mem_err  out  1  sticky timeout flag

Behaviour:
- Reset: all metadata registers 0, FSM in RUN, mem_err 0.
- Registered outputs reset to 0; combinational outputs during reset are pc_en=0, ifid_en=0, flushes=0, pipe_hold=0.
- Metadata write rules:
  - Any stage with regwrite=0 or rd=0 stores rd=0 and regwrite=0.
  - Destinations are therefore never nonzero without a write.
- FSM states:
  - RUN:
    - Hazard checks are evaluated in priority order (see below).
    - Otherwise all enables are 1 and metadata advances ID->EX->MEM->WB each cycle.
  - MEMWAIT:
    - pc_en=0, ifid_en=0, pipe_hold=1; IF/ID, ID/EX and EX/MEM hold.
    - MEM/WB loads a bubble (regwrite=0, rd=0).
    - Wait counter increments each cycle.
    - On dmem_ready: advance normally that cycle, go to RUN, clear the counter.
    - Counter reaching MEM_TIMEOUT sets mem_err; the FSM stays in MEMWAIT.
- Hazard priority in RUN, highest first:
  - Memory wait:
    - Condition: EX/MEM holds a load/store and dmem_ready=0.
    - Enter MEMWAIT this cycle; pipe_hold=1 combinationally.
    - A same-cycle branch/load-use is deferred: inputs are re-sampled after the wait.
  - Branch flush:
    - Condition: ex_branch_taken=1.
    - ifid_flush=1, idex_flush=1, pc_en=1. Suppresses any load-use stall in the same cycle.
  - Load-use stall:
    - Condition: id_valid, ID/EX memread, ID/EX rd!=0, and (rd==id_rs1 or rd==id_rs2).
    - pc_en=0, ifid_en=0, idex_flush=1 for exactly one cycle; the next cycle re-evaluates.
- Latency:
  - Stall/flush outputs are combinational from current registers and inputs.
  - Metadata moves one stage per enabled cycle.
- Reset mid-MEMWAIT: returns to RUN with all metadata cleared; mem_err is cleared only by rst.
- Counter saturates at MEM_TIMEOUT; no wrap.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_lu_stalls, perf_flushes and perf_mem_wait, each CNT_W wide.
  - Each counter increments once per cycle of its condition, wraps modulo 2^CNT_W, and resets to 0.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - typedef stage_meta_t struct with fields rs1, rs2, rd, regwrite, memread, memwrite.
  - enum ctrl_state_e {RUN, MEMWAIT}.
  - Constant REG_ZERO = 5'd0.
- One natural sub-module, pipe_meta_reg: a single stage_meta_t register with en, flush and async rst, instantiated three times.

Test Plan:
- Load x5 followed by add x6,x5,x1 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle exmem_dest=5, exmem_regwrite=1.
- ex_branch_taken=1 while the load-use condition is true -> ifid_flush=1, idex_flush=1, pc_en=1, no stall cycle.
- Load in EX/MEM, dmem_ready low 3 cycles -> pipe_hold=1 for 3 cycles, memwb_regwrite=0 during the wait, then the load reaches MEM/WB with memwb_dest correct.
- dmem_ready held low for 16 cycles -> mem_err=1 on the 16th and stays 1; reset -> 0.
- Instruction addi x0,x0,1 -> exmem_dest=0, exmem_regwrite=0 through all stages.
- Assert rst during MEMWAIT -> next clk: FSM RUN, all dest outputs 0, pc_en=1.
